// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller, register file and wrapper.
//   AWIDTH   default address width (FIFO depth = 2**AWIDTH)
//   DEPTH    default number of entries
//   op_e     per-edge operation, encoded as {push accepted, pop accepted}
package fifo_pkg;

  localparam int AWIDTH = 2;
  localparam int DEPTH  = 2 ** AWIDTH;
  localparam int DWIDTH = 8;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic push_ok, input logic pop_ok);
    return op_e'({push_ok, pop_ok});
  endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO: fifo_ctrl driving a reg_file. rdata is the head word and
// is valid whenever empty is low.
// Optional feature macro: FIFO_CTRL_LEVEL_EN exposes the occupancy `level`.
//   clk, reset  clock and synchronous active-high reset
//   wr, wdata   push request and data
//   rd          pop request
//   rdata       head word
//   full/empty  status flags
//   level       occupancy (FIFO_CTRL_LEVEL_EN only)
module fifo
  import fifo_pkg::*;
#(
  parameter int Awidth = AWIDTH,
  parameter int Dwidth = DWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [Dwidth-1:0] wdata,
  output logic [Dwidth-1:0] rdata,
  output logic              full,
  output logic              empty
`ifdef FIFO_CTRL_LEVEL_EN
  ,
  output logic [Awidth:0]   level
`endif
);

  logic              wren;
  logic [Awidth-1:0] waddr;
  logic [Awidth-1:0] raddr;

  fifo_ctrl #(.Awidth(Awidth)) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .rd    (rd),
    .wren  (wren),
    .waddr (waddr),
    .raddr (raddr),
    .full  (full),
    .empty (empty)
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    .level (level)
`endif
  );

  reg_file #(.Awidth(Awidth), .Dwidth(Dwidth)) u_rf (
    .clk   (clk),
    .wren  (wren),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: rtl/reg_file.sv
// Dual-address register file: one synchronous write port, one combinational
// read port. No reset; contents are only meaningful once written.
//   clk    in   rising-edge clock
//   wren   in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  combinational read data at raddr
module reg_file
  import fifo_pkg::*;
#(
  parameter int Awidth = AWIDTH,
  parameter int Dwidth = DWIDTH
) (
  input  logic              clk,
  input  logic              wren,
  input  logic [Awidth-1:0] waddr,
  input  logic [Dwidth-1:0] wdata,
  input  logic [Awidth-1:0] raddr,
  output logic [Dwidth-1:0] rdata
);

  logic [Dwidth-1:0] mem [2**Awidth];

  always_ff @(posedge clk) begin
    if (wren) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO around a dual-address
// register file. Turns push/pop requests into write enable plus write/read
// addresses and tracks full/empty. The file's combinational rdata at raddr is
// the FIFO head.
//
// Optional feature macro: FIFO_CTRL_LEVEL_EN adds a registered occupancy
// output `level`; without it the port and counter are absent.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (overrides wr/rd)
//   wr     in   push request; data sits on the file's wdata this cycle
//   rd     in   pop request; head word is consumed at this edge
//   wren   out  write enable to the file (combinational, accepted push)
//   waddr  out  write pointer (registered)
//   raddr  out  read pointer / head of queue (registered)
//   full   out  no free entry (registered)
//   empty  out  no valid entry (registered)
//   level  out  occupancy 0..2**Awidth (FIFO_CTRL_LEVEL_EN only)
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int Awidth = AWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  output logic              wren,
  output logic [Awidth-1:0] waddr,
  output logic [Awidth-1:0] raddr,
  output logic              full,
  output logic              empty
`ifdef FIFO_CTRL_LEVEL_EN
  ,
  output logic [Awidth:0]   level
`endif
);

  localparam logic [Awidth-1:0] PTR_ONE = Awidth'(1);

  logic              push_ok;
  logic              pop_ok;
  logic [Awidth-1:0] waddr_inc;
  logic [Awidth-1:0] raddr_inc;

  // A push while full is still accepted when a pop frees the head slot at the
  // same edge; the file reads the old head and overwrites it simultaneously.
  assign push_ok   = wr & (~full | rd);
  assign pop_ok    = rd & ~empty;
  assign wren      = push_ok & ~reset;

  // Natural wrap: pointers are exactly Awidth bits, no extra lap bit.
  assign waddr_inc = waddr + PTR_ONE;
  assign raddr_inc = raddr + PTR_ONE;

`ifdef FIFO_CTRL_LEVEL_EN
  localparam logic [Awidth:0] LVL_ONE = (Awidth + 1)'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr <= '0;
      raddr <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
`ifdef FIFO_CTRL_LEVEL_EN
      level <= '0;
`endif
    end else begin
      case (decode_op(push_ok, pop_ok))
        OP_PUSH: begin
          waddr <= waddr_inc;
          empty <= 1'b0;
          full  <= (waddr_inc == raddr);
`ifdef FIFO_CTRL_LEVEL_EN
          level <= level + LVL_ONE;
`endif
        end
        OP_POP: begin
          raddr <= raddr_inc;
          full  <= 1'b0;
          empty <= (raddr_inc == waddr);
`ifdef FIFO_CTRL_LEVEL_EN
          level <= level - LVL_ONE;
`endif
        end
        OP_BOTH: begin
          // Occupancy unchanged, so flags and level hold.
          waddr <= waddr_inc;
          raddr <= raddr_inc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl (Awidth=2). The register file is modelled in the bench
// so data ordering through the pointers can be checked against an ideal queue.
module tb_fifo_ctrl;

  localparam int AW = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset, wr, rd;
  logic [7:0]    wdata;
  logic          wren, full, empty;
  logic [AW-1:0] waddr, raddr;
`ifdef FIFO_CTRL_LEVEL_EN
  logic [AW:0]   level;
`endif

  fifo_ctrl #(.Awidth(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .rd    (rd),
    .wren  (wren),
    .waddr (waddr),
    .raddr (raddr),
    .full  (full),
    .empty (empty)
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    .level (level)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Register file model written by the DUT's own wren/waddr.
  logic [7:0] mem [D];
  always @(posedge clk) if (wren) mem[waddr] <= wdata;

  // Reference: ideal queue plus push/pop totals for expected pointer values.
  logic [7:0] q[$];
  int         npush, npop;
  // Scoreboard: per cycle {expected wren, expected pop}; popped data words.
  logic [1:0] exp_ctl[$];
  logic [7:0] exp_data[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: check post-edge state, apply new inputs, advance the model.
  task automatic cycle(input logic r, input logic w, input logic p, input logic [7:0] d);
    logic pa, pp, isfull;
    @(posedge clk); #1;
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("full",  int'(full),  int'(q.size() == D));
    chk("waddr", int'(waddr), npush % D);
    chk("raddr", int'(raddr), npop % D);
`ifdef FIFO_CTRL_LEVEL_EN
    chk("level", int'(level), q.size());
`endif
    reset = r; wr = w; rd = p; wdata = d;
    if (r) begin
      q.delete(); npush = 0; npop = 0;
      exp_ctl.push_back(2'b00);
    end else begin
      isfull = (q.size() == D);
      pa = w && (!isfull || p);
      pp = p && (q.size() > 0);
      if (pp) begin
        exp_data.push_back(q[0]);
        void'(q.pop_front());
        npop++;
      end
      if (pa) begin
        q.push_back(d);
        npush++;
      end
      exp_ctl.push_back({pa, pp});
    end
  endtask

  // Monitor: compares wren every cycle and the head word on every real pop.
  always @(negedge clk) begin
    logic [1:0] e;
    if (exp_ctl.size() > 0) begin
      e = exp_ctl.pop_front();
      chk("wren", int'(wren), int'(e[1]));
      chk("pop_seen", int'(rd && !empty && !reset), int'(e[0]));
      if (e[0]) begin
        if (exp_data.size() == 0) chk("data_queue", 0, 1);
        else chk("rdata", int'(mem[raddr]), int'(exp_data.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] seed_d;
    reset = 1'b1; wr = 1'b1; rd = 1'b1; wdata = 8'h00;
    npush = 0; npop = 0;
    for (int i = 0; i < D; i++) mem[i] = 8'h00;

    // Reset held with both requests active.
    cycle(1, 1, 1, 8'h00);
    cycle(1, 1, 1, 8'h00);

    // Fill to full, then a dropped push.
    cycle(0, 1, 0, 8'h11);
    cycle(0, 1, 0, 8'h22);
    cycle(0, 1, 0, 8'h33);
    cycle(0, 1, 0, 8'h44);
    cycle(0, 1, 0, 8'h55);

    // Drain in order, then an ignored pop on empty.
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'h00);

    // Push+pop on empty: write only.
    cycle(0, 1, 1, 8'hA5);

    // Fill, then push+pop while full, then drain.
    cycle(0, 1, 0, 8'hB1);
    cycle(0, 1, 0, 8'hB2);
    cycle(0, 1, 0, 8'hB3);
    cycle(0, 1, 1, 8'h99);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'h00);

    // Random traffic with a reset pulse mid-stream.
    for (int i = 0; i < 1000; i++) begin
      seed_d = 8'($urandom);
      cycle((i == 500 || i == 501), ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), seed_d);
    end

    cycle(0, 0, 0, 8'h00);
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_ctl.size() + exp_data.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
